crossbar_sched: RTL and testbench
=================================

CROSSBAR_SCHED -- requirements
Module: crossbar_sched

Interface
REQ-001 Parameter: DEPTH, 4, number of schedule table entries (index width 2).
REQ-002 Parameter: DWELL_W, 4, dwell-count width per entry.
REQ-003 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-004 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-005 Port: rst  input  1  synchronous active-high reset.
REQ-006 Port: wr_en  input  1  table write strobe.
REQ-007 Port: wr_addr  input  2  table entry index to write.
REQ-008 Port: wr_ctrl  input  5  crossbar control word for the entry.
REQ-009 Port: wr_dwell  input  DWELL_W  dwell count for the entry.
REQ-010 Port: num_entries  input  2  last entry index used (entries used = num_entries+1).
REQ-011 Port: start  input  1  begin schedule.
REQ-012 Port: stop  input  1  abort or terminate schedule.
REQ-013 Port: control  output  5  drives the 4x4 crossbar control bus (bit i = 2x2 switch Ci).
REQ-014 Port: entry_idx  output  2  index of the entry currently applied.
REQ-015 Port: switch_pulse  output  1  one-cycle strobe when a new entry is applied.
REQ-016 Port: busy  output  1  high in RUN.
REQ-017 Port: done  output  1  one-cycle strobe on schedule end.

Function
REQ-018 FSM states SHALL be IDLE, RUN and DONE, and all outputs SHALL be registered.
REQ-019 A write SHALL update table[wr_addr] {ctrl, dwell} only when wr_en=1 in IDLE, and SHALL be ignored in RUN/DONE.
REQ-020 In IDLE, start=1 with wr_en=0 SHALL, at the next edge: enter RUN, latch num_entries, set entry_idx=0, control=table[0].ctrl, counter=table[0].dwell, switch_pulse=1.
REQ-021 In IDLE, start=1 with wr_en=1 in the same cycle SHALL perform the write and ignore start.
REQ-022 In RUN, each entry SHALL be held for exactly dwell+1 cycles: decrement while counter≠0; at 0, advance.
REQ-023 On advance with entry_idx < latched num_entries, the block SHALL increment entry_idx, load control and counter from the new entry, and pulse switch_pulse.
REQ-024 On advance with entry_idx = latched num_entries, the block SHALL end the pass (see REQ-031/032).
REQ-025 stop=1 in RUN SHALL enter DONE at the next edge regardless of counter; stop coinciding with end-of-pass SHALL produce a single DONE.
REQ-026 In DONE the block SHALL hold for one cycle: done=1, busy=0, control=0, entry_idx=0; next state IDLE.
REQ-027 In IDLE the block SHALL hold control=0 (all switches straight: out1..out4 = in1..in4), busy=0, done=0, switch_pulse=0.
REQ-028 start in RUN/DONE and stop in IDLE/DONE SHALL be ignored; changes to num_entries during RUN SHALL be ignored.
REQ-029 A single pass SHALL keep busy high for exactly Σ(dwell_i+1) cycles over entries 0..num_entries.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE, control=0, entry_idx=0, busy=0, done=0, switch_pulse=0, all table entries {0,0} and counter=0, including mid-RUN with no done pulse.

Configuration
REQ-031 With macro CROSSBAR_SCHED_LOOP_EN defined, end-of-pass SHALL wrap to entry 0 (entry_idx=0, reload table[0], switch_pulse=1) and RUN SHALL continue until stop or rst.
REQ-032 Without CROSSBAR_SCHED_LOOP_EN, end-of-pass SHALL enter DONE (single-shot); stop behaviour is unchanged.

Verification
REQ-033 Reset then idle: rst=1 for 2 cycles -> control=0, busy=0, done=0; start with num_entries=0 -> entry 0 {0,0} applied for 1 cycle, then done.
REQ-034 Single pass: table {5'h01,d=2},{5'h06,d=0},{5'h1F,d=1}, num_entries=2, start -> control 01 for 3 cycles, 06 for 1, 1F for 2, switch_pulse at each change, busy 6 cycles, done 1 cycle, control back to 0.
REQ-035 Stop mid-run: same table, stop asserted on the 2nd cycle of entry 0 -> DONE next edge, done=1 once, no further switch_pulse.
REQ-036 Write protection: wr_en to entry 0 with ctrl=5'h1F during RUN -> table unchanged; a rerun shows the original ctrl; wr_en+start in the same IDLE cycle -> write lands, busy stays 0.
REQ-037 Reset mid-run: rst during entry 1 -> next cycle IDLE, control=0, no done, table cleared.
REQ-038 Loop build (CROSSBAR_SCHED_LOOP_EN): num_entries=1 -> after entry 1, entry_idx wraps to 0 with switch_pulse and no done; stop -> done once.

Source files
------------

// File: rtl/crossbar_sched_if.sv
// Handshake/bus bundle for crossbar_sched: table-write port, run control and
// crossbar outputs. The DUT uses the slave modport, its driver uses master.
interface crossbar_sched_if #(
  parameter int DEPTH   = 4,
  parameter int DWELL_W = 4
);
  localparam int IDX_W = $clog2(DEPTH);

  logic               wr_en;
  logic [IDX_W-1:0]   wr_addr;
  logic [4:0]         wr_ctrl;
  logic [DWELL_W-1:0] wr_dwell;
  logic [IDX_W-1:0]   num_entries;
  logic               start;
  logic               stop;
  logic [4:0]         control;
  logic [IDX_W-1:0]   entry_idx;
  logic               switch_pulse;
  logic               busy;
  logic               done;

  modport master (
    output wr_en, wr_addr, wr_ctrl, wr_dwell, num_entries, start, stop,
    input  control, entry_idx, switch_pulse, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_ctrl, wr_dwell, num_entries, start, stop,
    output control, entry_idx, switch_pulse, busy, done
  );
endinterface

// File: rtl/crossbar_sched.sv
// Table-driven 4x4 crossbar scheduler: applies {ctrl, dwell} entries in order.
// Define CROSSBAR_SCHED_LOOP_EN to wrap to entry 0 at end of pass instead of stopping.
module crossbar_sched #(
  parameter int DEPTH   = 4,
  parameter int DWELL_W = 4
) (
  input logic              clk,
  input logic              rst,
  crossbar_sched_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             r_state;
  logic [4:0]         r_ctrl  [DEPTH];
  logic [DWELL_W-1:0] r_dwell [DEPTH];
  logic [DWELL_W-1:0] r_cnt;
  logic [IDX_W-1:0]   r_last;
  logic [IDX_W-1:0]   r_idx;
  logic [4:0]         r_control;
  logic               r_pulse;
  logic               r_busy;
  logic               r_done;
  logic [IDX_W-1:0]   w_next_idx;

  assign w_next_idx       = r_idx + IDX_W'(1);
  assign bus.control      = r_control;
  assign bus.entry_idx    = r_idx;
  assign bus.switch_pulse = r_pulse;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_last    <= '0;
      r_idx     <= '0;
      r_control <= '0;
      r_pulse   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_ctrl[IDX_W'(i)]  <= '0;
        r_dwell[IDX_W'(i)] <= '0;
      end
    end else begin
      r_pulse <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.wr_en) begin
            r_ctrl[bus.wr_addr]  <= bus.wr_ctrl;
            r_dwell[bus.wr_addr] <= bus.wr_dwell;
          end else if (bus.start) begin
            r_state   <= RUN;
            r_last    <= bus.num_entries;
            r_idx     <= '0;
            r_control <= r_ctrl[0];
            r_cnt     <= r_dwell[0];
            r_pulse   <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        RUN: begin
          // stop wins over end-of-pass so the two together yield one DONE
          if (bus.stop) begin
            r_state   <= DONE;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_control <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - DWELL_W'(1);
          end else if (r_idx < r_last) begin
            r_idx     <= w_next_idx;
            r_control <= r_ctrl[w_next_idx];
            r_cnt     <= r_dwell[w_next_idx];
            r_pulse   <= 1'b1;
          end else begin
`ifdef CROSSBAR_SCHED_LOOP_EN
            r_idx     <= '0;
            r_control <= r_ctrl[0];
            r_cnt     <= r_dwell[0];
            r_pulse   <= 1'b1;
`else
            r_state   <= DONE;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_control <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
`endif
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_crossbar_sched.sv
// Scoreboard bench for crossbar_sched: a reference model expands each pass into
// a per-cycle plan and queues expected switch/done events for the monitor.
module tb_crossbar_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  crossbar_sched_if #(.DEPTH(4), .DWELL_W(4)) bus ();

  crossbar_sched #(.DEPTH(4), .DWELL_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [4:0] ctrl;
    logic [1:0] idx;
    logic       pulse;
    logic       busy;
    logic       done;
  } cyc_t;

  typedef struct {
    bit         is_done;
    logic [4:0] ctrl;
    logic [1:0] idx;
  } ev_t;

  cyc_t       plan[$];
  cyc_t       cur = '0;
  ev_t        sbq[$];
  logic [4:0] m_ctrl  [4];
  logic [3:0] m_dwell [4];
  int         m_last = 0;
  bit         mon_en = 0;
  int         n_chk  = 0;
  int         n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // One plan element per cycle the entry is held; the first of each entry carries the strobe.
  function automatic void expand(input int last);
    for (int e = 0; e <= last; e++)
      for (int c = 0; c <= int'(m_dwell[e]); c++)
        plan.push_back('{ctrl: m_ctrl[e], idx: 2'(e), pulse: (c == 0), busy: 1'b1, done: 1'b0});
  endfunction

  // Reference model: predicts what the DUT shows after each rising edge.
  always @(posedge clk) begin
    cyc_t nxt;
    nxt = '0;
    if (rst) begin
      mon_en = 1;
      plan.delete();
      for (int i = 0; i < 4; i++) begin
        m_ctrl[i]  = '0;
        m_dwell[i] = '0;
      end
    end else if (cur.busy) begin
      if (bus.stop) begin
        nxt.done = 1'b1;
        plan.delete();
      end else begin
`ifdef CROSSBAR_SCHED_LOOP_EN
        if (plan.size() == 0) expand(m_last);
`endif
        if (plan.size() > 0) nxt = plan.pop_front();
        else nxt.done = 1'b1;
      end
    end else if (!cur.done) begin
      if (bus.wr_en) begin
        m_ctrl[bus.wr_addr]  = bus.wr_ctrl;
        m_dwell[bus.wr_addr] = bus.wr_dwell;
      end else if (bus.start) begin
        m_last = int'(bus.num_entries);
        plan.delete();
        expand(m_last);
        nxt = plan.pop_front();
      end
    end
    cur = nxt;
    if (nxt.pulse) sbq.push_back('{is_done: 1'b0, ctrl: nxt.ctrl, idx: nxt.idx});
    if (nxt.done)  sbq.push_back('{is_done: 1'b1, ctrl: 5'd0, idx: 2'd0});
  end

  // Monitor: per-cycle level checks plus scoreboard pops on every strobe.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("control", int'(bus.control), int'(cur.ctrl));
      chk("entry_idx", int'(bus.entry_idx), int'(cur.idx));
      chk("busy", int'(bus.busy), int'(cur.busy));
      chk("switch_pulse", int'(bus.switch_pulse), int'(cur.pulse));
      chk("done", int'(bus.done), int'(cur.done));
      if (bus.switch_pulse === 1'b1 || bus.done === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected_event", 1, 0);
        end else begin
          ev_t e;
          e = sbq.pop_front();
          chk("sb_kind_done", int'(bus.done), int'(e.is_done));
          if (!e.is_done) begin
            chk("sb_ctrl", int'(bus.control), int'(e.ctrl));
            chk("sb_idx", int'(bus.entry_idx), int'(e.idx));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [4:0] c, input logic [3:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_ctrl = c; bus.wr_dwell = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic start_run(input logic [1:0] n);
    bus.num_entries = n; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  // Bounded wait for the model to return to idle; looping runs are stopped instead.
  task automatic wait_idle(input int max_cyc);
    int k;
    k = 0;
    while ((cur.busy || cur.done) && k < max_cyc) begin
      tick();
      k++;
    end
    if (cur.busy) begin
`ifdef CROSSBAR_SCHED_LOOP_EN
      do_stop();
`else
      chk("wait_idle_bound", 1, 0);
      do_stop();
`endif
    end
    repeat (3) tick();
  endtask

  task automatic load_ref_table();
    wr(2'd0, 5'h01, 4'd2);
    wr(2'd1, 5'h06, 4'd0);
    wr(2'd2, 5'h1F, 4'd1);
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_ctrl = '0; bus.wr_dwell = '0;
    bus.num_entries = '0; bus.start = 1'b0; bus.stop = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Cleared table, single entry of dwell 0
    start_run(2'd0);
    wait_idle(20);

    // Single pass over three entries
    load_ref_table();
    start_run(2'd2);
    wait_idle(30);

    // Stop on the second cycle of entry 0
    start_run(2'd2);
    do_stop();
    wait_idle(10);

    // Writes during RUN are dropped; write+start in IDLE writes only
    start_run(2'd2);
    bus.num_entries = 2'd0;
    wr(2'd0, 5'h1F, 4'd3);
    wait_idle(30);
    start_run(2'd2);
    wait_idle(30);
    bus.wr_en = 1'b1; bus.wr_addr = 2'd3; bus.wr_ctrl = 5'h0A; bus.wr_dwell = 4'd1;
    bus.start = 1'b1; bus.num_entries = 2'd3;
    tick();
    bus.wr_en = 1'b0; bus.start = 1'b0;
    repeat (2) tick();
    start_run(2'd3);
    wait_idle(30);

    // Reset during entry 1 clears the table
    start_run(2'd2);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    start_run(2'd3);
    wait_idle(20);

    // Short two-entry schedule held long enough to see a wrap in the loop build
    wr(2'd0, 5'h03, 4'd1);
    wr(2'd1, 5'h14, 4'd1);
    start_run(2'd1);
    repeat (8) tick();
    do_stop();
    wait_idle(10);

    // Randomized traffic, including inputs during RUN/DONE and occasional reset
    for (int i = 0; i < 3000; i++) begin
      bus.wr_en       = ($urandom_range(0, 3) == 0);
      bus.wr_addr     = 2'($urandom_range(0, 3));
      bus.wr_ctrl     = 5'($urandom_range(0, 31));
      bus.wr_dwell    = 4'($urandom_range(0, 15));
      bus.num_entries = 2'($urandom_range(0, 3));
      bus.start       = ($urandom_range(0, 5) == 0);
      bus.stop        = ($urandom_range(0, 24) == 0);
      rst             = ($urandom_range(0, 199) == 0);
      tick();
    end
    bus.wr_en = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; rst = 1'b0;
    tick();
    wait_idle(80);

    chk("sb_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
